// File: rtl/sudoku_stream_loader.sv
// Streams a puzzle into the solver RAM wrapper, starts the solver and streams the result back out.
// Optional solver watchdog is compiled in with SUDOKU_LOADER_TIMEOUT_EN.
module sudoku_stream_loader #(
   parameter int unsigned NCELLS         = 81,
   parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       in_valid_i,
   output logic       in_ready_o,
   input  logic [3:0] in_data_i,
   output logic       out_valid_o,
   input  logic       out_ready_i,
   output logic [3:0] out_data_o,
   output logic       out_last_o,
   output logic [6:0] sol_addr_o,
   output logic       sol_wr_o,
   output logic [8:0] sol_din_o,
   input  logic [8:0] sol_dout_i,
   output logic       sol_start_o,
   input  logic       sol_done_i,
   input  logic       sol_error_i,
   output logic       busy_o,
   output logic       result_err_o,
   output logic       bad_digit_o
);

   localparam logic [6:0] LastCell = 7'(NCELLS - 1);

   typedef enum logic [2:0] {StLoad, StStart, StWait, StSettle, StUnload} state_e;

   state_e     state_q, state_d;
   logic [6:0] cnt_q, cnt_d;
   logic [6:0] wr_addr_q, wr_addr_d;
   logic [8:0] sol_din_q, sol_din_d;
   logic       sol_wr_q, sol_wr_d;
   logic       sol_start_q, sol_start_d;
   logic       result_err_q, result_err_d;
   logic       bad_digit_q, bad_digit_d;
   logic       wd_hit;

   function automatic logic [8:0] encode(input logic [3:0] d);
      if (d == 4'd0 || d > 4'd9) return 9'h1FF;
      return 9'd1 << (d - 4'd1);
   endfunction

   function automatic logic [3:0] decode(input logic [8:0] m);
      logic [3:0] d;
      logic [3:0] n;
      d = 4'd0;
      n = 4'd0;
      for (int k = 0; k < 9; k++) begin
         if (m[k]) begin
            n = n + 4'd1;
            d = 4'(k + 1);
         end
      end
      return (n == 4'd1) ? d : 4'd0;
   endfunction

`ifdef SUDOKU_LOADER_TIMEOUT_EN
   localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WdW-1:0] wd_q, wd_d;

   // Counter is zero on the first WAIT cycle because it clears in every other state.
   assign wd_d   = (state_q == StWait) ? wd_q + WdW'(1) : '0;
   assign wd_hit = (wd_q == WdW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk_i) begin
      if (rst_i) wd_q <= '0;
      else       wd_q <= wd_d;
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      wr_addr_d    = wr_addr_q;
      sol_din_d    = sol_din_q;
      sol_wr_d     = 1'b0;
      sol_start_d  = 1'b0;
      result_err_d = result_err_q;
      bad_digit_d  = bad_digit_q;
      unique case (state_q)
         StLoad: begin
            if (in_valid_i) begin
               sol_wr_d  = 1'b1;
               wr_addr_d = cnt_q;
               sol_din_d = encode(in_data_i);
               if (in_data_i > 4'd9) bad_digit_d = 1'b1;
               if (cnt_q == LastCell) begin
                  cnt_d   = 7'd0;
                  state_d = StStart;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         StStart: begin
            sol_start_d = 1'b1;
            state_d     = StWait;
         end
         StWait: begin
            if (sol_done_i || sol_error_i) begin
               result_err_d = sol_error_i;
               state_d      = StSettle;
            end else if (wd_hit) begin
               result_err_d = 1'b1;
               state_d      = StSettle;
            end
         end
         StSettle: state_d = StUnload;
         StUnload: begin
            if (out_ready_i) begin
               if (cnt_q == LastCell) begin
                  cnt_d   = 7'd0;
                  state_d = StLoad;
               end else begin
                  cnt_d = cnt_q + 7'd1;
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StLoad;
         cnt_q        <= 7'd0;
         wr_addr_q    <= 7'd0;
         sol_din_q    <= 9'd0;
         sol_wr_q     <= 1'b0;
         sol_start_q  <= 1'b0;
         result_err_q <= 1'b0;
         bad_digit_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         wr_addr_q    <= wr_addr_d;
         sol_din_q    <= sol_din_d;
         sol_wr_q     <= sol_wr_d;
         sol_start_q  <= sol_start_d;
         result_err_q <= result_err_d;
         bad_digit_q  <= bad_digit_d;
      end
   end

   // Readback address is combinational so sol_dout tracks the cell being offered.
   assign sol_addr_o   = (state_q == StUnload || state_q == StSettle) ? cnt_q : wr_addr_q;
   assign sol_wr_o     = sol_wr_q;
   assign sol_din_o    = sol_din_q;
   assign sol_start_o  = sol_start_q;
   assign in_ready_o   = (state_q == StLoad);
   assign out_valid_o  = (state_q == StUnload);
   assign out_data_o   = out_valid_o ? decode(sol_dout_i) : 4'd0;
   assign out_last_o   = out_valid_o && (cnt_q == LastCell);
   assign busy_o       = !((state_q == StLoad) && (cnt_q == 7'd0));
   assign result_err_o = result_err_q;
   assign bad_digit_o  = bad_digit_q;

endmodule

// File: tb/tb_sudoku_stream_loader.sv
// Self-checking bench for sudoku_stream_loader with a behavioural solver/RAM model.
module tb_sudoku_stream_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [3:0] in_data = 4'd0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [3:0] out_data;
   logic       out_last;
   logic [6:0] sol_addr;
   logic       sol_wr;
   logic [8:0] sol_din;
   logic [8:0] sol_dout;
   logic       sol_start;
   logic       sol_done;
   logic       sol_error;
   logic       busy;
   logic       result_err;
   logic       bad_digit;

   always #5 clk = ~clk;

   sudoku_stream_loader #(.NCELLS(81), .TIMEOUT_CYCLES(64)) dut (
      .clk_i(clk), .rst_i(rst),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_last_o(out_last),
      .sol_addr_o(sol_addr), .sol_wr_o(sol_wr), .sol_din_o(sol_din), .sol_dout_i(sol_dout),
      .sol_start_o(sol_start), .sol_done_i(sol_done), .sol_error_i(sol_error),
      .busy_o(busy), .result_err_o(result_err), .bad_digit_o(bad_digit)
   );

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_err = 0;

   // Solver/RAM model state. solver_mode: 0 done, 1 error, 2 silent, 3 done+error.
   logic [8:0] mem [128];
   logic [8:0] grid [81];
   logic [3:0] dig [81];
   logic [8:0] exp_wr [81];
   int         solver_mode = 0;
   int         solver_delay = 10;
   int         cd = 0;
   int         start_cnt = 0;
   int         start_edge = 0;
   int         wr_cnt = 0;
   logic [6:0] wr_a [2048];
   logic [8:0] wr_d [2048];

   assign sol_dout = mem[sol_addr];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (sol_wr) begin
         mem[sol_addr]       <= sol_din;
         wr_a[wr_cnt % 2048] <= sol_addr;
         wr_d[wr_cnt % 2048] <= sol_din;
         wr_cnt              <= wr_cnt + 1;
      end
      if (sol_start) begin
         start_cnt  <= start_cnt + 1;
         start_edge <= cyc;
      end
      sol_done  <= 1'b0;
      sol_error <= 1'b0;
      if (rst) begin
         cd <= 0;
      end else if (sol_start && solver_mode != 2) begin
         cd <= solver_delay;
      end else if (cd > 0) begin
         cd <= cd - 1;
         if (cd == 1) begin
            for (int i = 0; i < 81; i++) mem[i] <= grid[i];
            sol_done  <= (solver_mode == 0 || solver_mode == 3);
            sol_error <= (solver_mode == 1 || solver_mode == 3);
         end
      end
   end

   typedef struct {
      logic [3:0] digit;
      logic [8:0] din;
   } enc_vec_t;
   enc_vec_t tab [16];

   function automatic logic [8:0] enc_ref(input logic [3:0] d);
      if (d == 0 || d > 9) return 9'h1FF;
      return 9'(1 << (d - 1));
   endfunction

   function automatic int dec_ref(input logic [8:0] m);
      if ($countones(m) == 1) return $clog2(m) + 1;
      return 0;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      last_err = 0;
   endtask

   // Loads dig[], lets the solver model respond, unloads and checks everything against the model.
   task automatic run_puzzle(input int rmode, input bit gaps, input int exp_err);
      int acc_edge, sc0, wc0, e, k, n;
      int exp_out [81];
      logic [3:0] prev;
      bit stalled;
      for (int i = 0; i < 81; i++)
         exp_out[i] = (solver_mode == 2) ? dec_ref(exp_wr[i]) : dec_ref(grid[i]);
      sc0 = start_cnt;
      wc0 = wr_cnt;
      acc_edge = 0;
      for (int i = 0; i < 81; i++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_data  = dig[i];
         chk("in_ready_load", in_ready, 1);
         if (i == 0) chk("result_err_held", result_err, last_err);
         if (i == 40) chk("busy_load", busy, 1);
         @(posedge clk);
         acc_edge = cyc;
         #1;
      end
      in_valid = 1'b0;
      chk("in_ready_after_last", in_ready, 0);
      n = 0;
      while (start_cnt == sc0 && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("start_seen", start_cnt - sc0, 1);
      chk("start_latency", start_edge - acc_edge, 2);
      for (int i = 0; i < 81; i++) begin
         chk("wr_addr", wr_a[(wc0 + i) % 2048], i);
         chk("wr_din", wr_d[(wc0 + i) % 2048], exp_wr[i]);
      end
      e = 0;
      for (int w = 0; w < 200; w++) begin
         @(posedge clk);
         e = cyc;
         #1;
         if (out_valid) break;
      end
      chk("unload_start", out_valid, 1);
      if (solver_mode == 2) chk("timeout_latency", e - acc_edge, 67);
      k = 0;
      stalled = 1'b0;
      prev = 4'd0;
      for (n = 0; n < 600 && k < 81; n++) begin
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = (n % 2 == 0);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         chk("out_valid", out_valid, 1);
         chk("out_data", out_data, exp_out[k]);
         chk("out_last", out_last, k == 80);
         if (stalled) chk("stall_stable", out_data, prev);
         prev = out_data;
         stalled = !out_ready;
         @(posedge clk);
         if (out_ready) k++;
         #1;
      end
      out_ready = 1'b0;
      chk("transfers", k, 81);
      chk("out_valid_after", out_valid, 0);
      chk("in_ready_after", in_ready, 1);
      chk("busy_after", busy, 0);
      chk("result_err", result_err, exp_err);
      chk("write_count", wr_cnt - wc0, 81);
      chk("start_count", start_cnt - sc0, 1);
      last_err = exp_err;
   endtask

   initial begin
      #5000000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1);
   end

   initial begin
      tab[0]  = '{4'd0,  9'h1FF}; tab[1]  = '{4'd1,  9'h001};
      tab[2]  = '{4'd2,  9'h002}; tab[3]  = '{4'd3,  9'h004};
      tab[4]  = '{4'd4,  9'h008}; tab[5]  = '{4'd5,  9'h010};
      tab[6]  = '{4'd6,  9'h020}; tab[7]  = '{4'd12, 9'h1FF};
      tab[8]  = '{4'd7,  9'h040}; tab[9]  = '{4'd8,  9'h080};
      tab[10] = '{4'd9,  9'h100}; tab[11] = '{4'd10, 9'h1FF};
      tab[12] = '{4'd11, 9'h1FF}; tab[13] = '{4'd13, 9'h1FF};
      tab[14] = '{4'd14, 9'h1FF}; tab[15] = '{4'd15, 9'h1FF};

      do_reset();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_sol_wr", sol_wr, 0);
      chk("rst_sol_start", sol_start, 0);
      chk("rst_sol_addr", sol_addr, 0);
      chk("rst_sol_din", sol_din, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result_err", result_err, 0);
      chk("rst_bad_digit", bad_digit, 0);

      // 30 givens: 37 is coprime to 81, so (i*37)%81 < 30 picks exactly 30 cells.
      for (int i = 0; i < 81; i++) begin
         int p;
         p = (i * 37) % 81;
         dig[i]    = (p < 30) ? 4'(p % 9 + 1) : 4'd0;
         exp_wr[i] = enc_ref(dig[i]);
         grid[i]   = 9'(1 << (i % 9));
      end
      solver_mode = 0;
      solver_delay = 10;
      run_puzzle(0, 1'b0, 0);
      chk("bad_digit_clean", bad_digit, 0);

      for (int i = 0; i < 81; i++) begin
         dig[i]    = 4'($urandom_range(0, 9));
         exp_wr[i] = enc_ref(dig[i]);
         grid[i]   = (i % 4 == 0) ? 9'h003 : 9'(1 << (i % 9));
      end
      solver_mode = 1;
      run_puzzle(1, 1'b0, 1);

      for (int i = 0; i < 81; i++) begin
         dig[i]    = tab[i % 16].digit;
         exp_wr[i] = tab[i % 16].din;
         grid[i]   = 9'(1 << ((i * 5) % 9));
      end
      solver_mode = 0;
      run_puzzle(1, 1'b0, 0);
      chk("bad_digit_set", bad_digit, 1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 81; i++) begin
            dig[i]    = 4'($urandom_range(0, 9));
            exp_wr[i] = enc_ref(dig[i]);
            grid[i]   = ($urandom_range(0, 3) == 0) ? 9'($urandom) : 9'(1 << $urandom_range(0, 8));
         end
         solver_mode  = (r == 0) ? 3 : ((r == 1) ? 1 : 0);
         solver_delay = int'($urandom_range(1, 20));
         run_puzzle(2, 1'b1, (solver_mode == 0) ? 0 : 1);
         chk("bad_digit_sticky", bad_digit, 1);
      end

`ifdef SUDOKU_LOADER_TIMEOUT_EN
      do_reset();
      for (int i = 0; i < 81; i++) begin
         dig[i]    = 4'($urandom_range(0, 9));
         exp_wr[i] = enc_ref(dig[i]);
      end
      solver_mode = 2;
      run_puzzle(0, 1'b0, 1);
`endif

      // Reset while the solver is still running.
      solver_mode = 2;
      for (int i = 0; i < 81; i++) begin
         in_valid = 1'b1;
         in_data  = 4'($urandom_range(0, 9));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("wait_busy", busy, 1);
      chk("wait_in_ready", in_ready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      last_err = 0;
      chk("rst_wait_in_ready", in_ready, 1);
      chk("rst_wait_busy", busy, 0);
      chk("rst_wait_sol_start", sol_start, 0);
      chk("rst_wait_out_valid", out_valid, 0);
      chk("rst_wait_bad_digit", bad_digit, 0);
      chk("rst_wait_result_err", result_err, 0);

      for (int i = 0; i < 81; i++) begin
         dig[i]    = 4'(i % 10);
         exp_wr[i] = enc_ref(dig[i]);
         grid[i]   = 9'(1 << ((i * 2) % 9));
      end
      solver_mode = 0;
      solver_delay = 3;
      run_puzzle(2, 1'b1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sudoku_stream_loader.md
Name: sudoku_stream_loader

Overview:
- Host-side sequencer sitting directly upstream and downstream of the solver RAM wrapper: it drives the wrapper's addr/wr/din/start pins and reads its dout/done/error.
- Accepts a puzzle as a stream of 81 decimal digits (row-major, 0 = empty) on a valid/ready input, encodes each into a 9-bit one-hot candidate mask and writes it into the wrapper RAM.
- Pulses start, waits for done/error, then reads the 81 result cells back, decodes them to digits and emits them on a valid/ready output stream.

Parameters:
- NCELLS, 81, number of grid cells loaded/unloaded per puzzle; address width fixed at 7 bits.
- TIMEOUT_CYCLES, 1048576, solver watchdog limit in clock cycles (used only when SUDOKU_LOADER_TIMEOUT_EN is defined).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  input digit valid
- in_ready  output  1  loader accepts a digit this cycle
- in_data  input  4  digit 0..9 (0 = empty cell)
- out_valid  output  1  output digit valid
- out_ready  input  1  downstream accepts output digit
- out_data  output  4  solved digit 1..9, 0 if cell not uniquely resolved
- out_last  output  1  high with the NCELLS-th output digit
- sol_addr  output  7  wrapper RAM address
- sol_wr  output  1  wrapper RAM write enable
- sol_din  output  9  wrapper RAM write data (one-hot mask)
- sol_dout  input  9  wrapper RAM read data, combinational from sol_addr
- sol_start  output  1  one-cycle solver start pulse
- sol_done  input  1  solver finished successfully
- sol_error  input  1  solver found puzzle inconsistent
- busy  output  1  high in every state except LOAD with cnt == 0
- result_err  output  1  error status of last completed solve, held until next solve completes
- bad_digit  output  1  sticky: an in_data value > 9 was accepted since reset

Behaviour:
- Clock clk, reset rst synchronous active-high. Reset: state LOAD, cnt 0, in_ready 1, out_valid 0, out_last 0, sol_wr 0, sol_start 0, sol_addr 0, sol_din 0, busy 0, result_err 0, bad_digit 0. Reset mid-operation abandons the puzzle immediately; the partially written wrapper RAM is left as is.
- Encoding: d in 1..9 -> sol_din = 1 << (d-1); d = 0 -> 9'h1FF; d in 10..15 -> 9'h1FF and bad_digit set.
- Decoding: sol_dout with exactly one bit set at position k -> out_data = k+1; zero or multiple bits set -> 0.
- cnt is a 7-bit cell counter, range 0..NCELLS-1.
- LOAD: in_ready = 1. On in_valid & in_ready, next cycle sol_wr = 1, sol_addr = cnt, sol_din = encoded digit (registered, one-cycle write latency), then cnt++. When cell NCELLS-1 is accepted: in_ready drops the following cycle, cnt clears, go to START.
- START: entered the cycle the final write is presented. The next cycle drives sol_start = 1 for exactly one cycle, sol_wr = 0, then go to WAIT.
- WAIT: sol_wr held 0, so the wrapper is free to copy the solver grid into RAM. The first cycle with sol_done | sol_error: result_err <= sol_error (error wins if both are high), go to SETTLE. Further done/error levels are ignored outside WAIT.
- SETTLE: one cycle, lets the wrapper RAM update land; sol_addr = 0. Go to UNLOAD.
- UNLOAD: sol_addr = cnt, out_valid = 1, out_data = decode(sol_dout) combinationally, out_last = (cnt == NCELLS-1). On out_valid & out_ready, cnt++. out_data must stay stable while stalled. After the last handshake, cnt = 0 and go to LOAD; in_ready rises the next cycle.
- in_ready is 0 outside LOAD. out_valid is 0 outside UNLOAD. No input digits are accepted while a result is being unloaded.

Optional Feature:
- Macro SUDOKU_LOADER_TIMEOUT_EN.
- Defined: a watchdog counter clears on entry to WAIT and increments each WAIT cycle. When it reaches TIMEOUT_CYCLES without done/error, go to SETTLE with result_err = 1; unload then proceeds normally (outputs whatever RAM holds).
- Undefined: no counter; WAIT lasts indefinitely.

Test Plan:
- Reset then stream 81 digits (puzzle with 30 givens), in_valid held 1 -> 81 writes at sol_addr 0..80; cell with digit 5 gives sol_din 9'h010; cell with 0 gives 9'h1FF; single sol_start pulse 2 cycles after the last accept.
- Solver model asserts sol_done 10 cycles after start with RAM cell i = 1 << (i%9) -> out_data sequence 1,2,...,9 repeated; out_last only on the 81st; result_err = 0.
- Solver model asserts sol_error -> result_err = 1 after unload; cells with mask 9'h003 decode to out_data 0.
- out_ready toggled 1/0 every cycle during unload -> exactly 81 transfers, no duplicated or skipped cell, out_data stable while stalled.
- in_data = 12 on cell 7 -> sol_din 9'h1FF at addr 7; bad_digit = 1 until rst.
- rst asserted during WAIT -> next cycle in_ready = 1, busy = 0, sol_start = 0. With SUDOKU_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES = 64, no done -> result_err = 1 and unload begins 66 cycles after start.
